// File: rtl/seq_mag_compare.sv
`default_nettype none
// ============================================================================
// Module      : seq_mag_compare
// Description : Digit-serial magnitude comparator, MS digit first, with early
//               exit on the first unequal digit; unsigned or two's complement.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mag_compare #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);
    localparam int c_NDIG  = WIDTH / DIGIT;
    localparam int c_IW    = (c_NDIG > 1) ? $clog2(c_NDIG) : 1;
    localparam int c_NSLOT = 1 << c_IW;
    localparam logic [WIDTH-1:0] c_MSB = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [c_IW-1:0]  r_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_gt;
    logic             r_eq;
    logic             r_lt;

    logic [DIGIT-1:0] w_dig_a [c_NSLOT];
    logic [DIGIT-1:0] w_dig_b [c_NSLOT];
    logic [DIGIT-1:0] w_cur_a;
    logic [DIGIT-1:0] w_cur_b;
    logic             w_dig_ne;
    logic             w_last;

    // Digit table padded to a power of two so r_idx indexes it at full width.
    generate
        for (genvar gi = 0; gi < c_NSLOT; gi++) begin : g_dig
            if (gi < c_NDIG) begin : g_real
                assign w_dig_a[gi] = r_a[gi*DIGIT +: DIGIT];
                assign w_dig_b[gi] = r_b[gi*DIGIT +: DIGIT];
            end else begin : g_pad
                assign w_dig_a[gi] = '0;
                assign w_dig_b[gi] = '0;
            end
        end
    endgenerate

    assign w_cur_a  = w_dig_a[r_idx];
    assign w_cur_b  = w_dig_b[r_idx];
    assign w_dig_ne = (w_cur_a != w_cur_b);
    assign w_last   = (r_idx == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_dig_ne || w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // Flipping the sign bit of both operands maps two's complement order
    // onto unsigned order, so the digit datapath never needs to know the mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
            r_gt  <= 1'b0;
            r_eq  <= 1'b0;
            r_lt  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a ^ (is_signed ? c_MSB : '0);
                        r_b   <= b ^ (is_signed ? c_MSB : '0);
                        r_idx <= c_IW'(c_NDIG - 1);
                    end
                end
                S_RUN: begin
                    if (w_dig_ne) begin
                        r_gt <= (w_cur_a > w_cur_b);
                        r_lt <= (w_cur_a < w_cur_b);
                        r_eq <= 1'b0;
                    end else if (w_last) begin
                        r_gt <= 1'b0;
                        r_lt <= 1'b0;
                        r_eq <= 1'b1;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign gt   = r_gt;
    assign eq   = r_eq;
    assign lt   = r_lt;

endmodule
`default_nettype wire

// File: tb/tb_seq_mag_compare.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mag_compare
// Description : Self-checking bench: vector table, corner sequences, random
//               16-bit compares and exhaustive 4-bit sweeps against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mag_compare;
    logic        clk;
    logic        rst_n;
    logic        start16, sgn16, busy16, done16, gt16, eq16, lt16;
    logic [15:0] a16, b16;
    logic        start4, sgn4;
    logic [3:0]  a4, b4;
    logic        busy4a, done4a, gt4a, eq4a, lt4a;
    logic        busy4b, done4b, gt4b, eq4b, lt4b;

    int total = 0;
    int bad   = 0;

    seq_mag_compare #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .is_signed(sgn16),
        .a(a16), .b(b16), .busy(busy16), .done(done16),
        .gt(gt16), .eq(eq16), .lt(lt16)
    );
    seq_mag_compare #(.WIDTH(4), .DIGIT(4)) dut4a (
        .clk(clk), .rst_n(rst_n), .start(start4), .is_signed(sgn4),
        .a(a4), .b(b4), .busy(busy4a), .done(done4a),
        .gt(gt4a), .eq(eq4a), .lt(lt4a)
    );
    seq_mag_compare #(.WIDTH(4), .DIGIT(1)) dut4b (
        .clk(clk), .rst_n(rst_n), .start(start4), .is_signed(sgn4),
        .a(a4), .b(b4), .busy(busy4b), .done(done4b),
        .gt(gt4b), .eq(eq4b), .lt(lt4b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    // Ordering from integer values; +1 a>b, 0 equal, -1 a<b.
    function automatic int ref_rel(int w, logic s, int ua, int ub);
        int sa = ua;
        int sb = ub;
        if (s) begin
            if (ua >= (1 << (w - 1))) sa = ua - (1 << w);
            if (ub >= (1 << (w - 1))) sb = ub - (1 << w);
        end
        return (sa > sb) ? 1 : ((sa < sb) ? -1 : 0);
    endfunction

    function automatic logic [2:0] rel_onehot(int r);
        return (r > 0) ? 3'b100 : ((r < 0) ? 3'b001 : 3'b010);
    endfunction

    // Done cycle = digits examined (up to and including first difference) + 1.
    function automatic int ref_lat(int w, int d, int ua, int ub);
        int n    = w / d;
        int mask = (1 << d) - 1;
        int m    = 0;
        for (int k = n - 1; k >= 0; k--) begin
            m++;
            if (((ua >> (k * d)) & mask) != ((ub >> (k * d)) & mask)) break;
        end
        return m + 1;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic run16(input logic [15:0] ta, input logic [15:0] tb,
                         input logic ts, output int lat, output logic [2:0] res);
        @(negedge clk);
        a16 = ta; b16 = tb; sgn16 = ts; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        lat = 1;
        while (!done16 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done16) lat = -1;
        res = {gt16, eq16, lt16};
        @(negedge clk);
        check("done_pulse_width", int'(done16), 0);
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic ts,
                        output int la, output logic [2:0] ra,
                        output int lb, output logic [2:0] rb);
        int lat;
        @(negedge clk);
        a4 = ta; b4 = tb; sgn4 = ts; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = 1; la = -1; lb = -1; ra = 3'b000; rb = 3'b000;
        repeat (20) begin
            if (done4a && la < 0) begin la = lat; ra = {gt4a, eq4a, lt4a}; end
            if (done4b && lb < 0) begin lb = lat; rb = {gt4b, eq4b, lt4b}; end
            if (la >= 0 && lb >= 0) break;
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [2:0]  res;   // {gt, eq, lt}
        int          lat;
    } vec_t;

    initial begin
        vec_t        vt[9];
        int          lat, la, lb, ndone, dcyc;
        logic [2:0]  res, ra, rb, dres;
        logic [15:0] ra16, rb16;
        logic        rs;

        vt[0] = '{16'h1234, 16'h1235, 1'b0, 3'b001, 5};
        vt[1] = '{16'h8000, 16'h7FFF, 1'b0, 3'b100, 2};
        vt[2] = '{16'h8000, 16'h7FFF, 1'b1, 3'b001, 2};
        vt[3] = '{16'hABCD, 16'hABCD, 1'b0, 3'b010, 5};
        vt[4] = '{16'hABCD, 16'hABCD, 1'b1, 3'b010, 5};
        vt[5] = '{16'hFFFF, 16'h0001, 1'b1, 3'b001, 2};
        vt[6] = '{16'h1200, 16'h1300, 1'b0, 3'b001, 3};
        vt[7] = '{16'h0005, 16'h0003, 1'b0, 3'b100, 5};
        vt[8] = '{16'hFFFE, 16'hFFFF, 1'b1, 3'b001, 5};

        rst_n = 1'b0;
        start16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
        start4 = 1'b0;  sgn4 = 1'b0;  a4 = '0;  b4 = '0;
        repeat (2) @(negedge clk);
        check("reset_w16", int'({busy16, done16, gt16, eq16, lt16}), 0);
        check("reset_w4d4", int'({busy4a, done4a, gt4a, eq4a, lt4a}), 0);
        check("reset_w4d1", int'({busy4b, done4b, gt4b, eq4b, lt4b}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run16(vt[i].a, vt[i].b, vt[i].s, lat, res);
            check($sformatf("vec%0d_result", i), int'(res), int'(vt[i].res));
            check($sformatf("vec%0d_latency", i), lat, vt[i].lat);
        end

        // Results hold through idle cycles while the operand inputs wander.
        run16(16'hABCD, 16'hABCD, 1'b0, lat, res);
        for (int c = 0; c < 10; c++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = 1'($urandom);
            @(negedge clk);
            check($sformatf("hold_c%0d", c),
                  int'({busy16, done16, gt16, eq16, lt16}), 5'b00010);
        end

        // Start pulses during a running compare are ignored.
        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h1235; sgn16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        ndone = 0; dcyc = 0; dres = 3'b000;
        for (int c = 1; c <= 10; c++) begin
            if (done16) begin ndone++; dcyc = c; dres = {gt16, eq16, lt16}; end
            start16 = (c == 2 || c == 3);
            if (start16) begin a16 = 16'hFFFF; b16 = 16'h0000; sgn16 = 1'b0; end
            @(negedge clk);
        end
        check("busy_start_ndone", ndone, 1);
        check("busy_start_cycle", dcyc, 5);
        check("busy_start_result", int'(dres), 3'b001);
        check("busy_start_idle", int'(busy16), 0);
        run16(16'h0005, 16'h0003, 1'b0, lat, res);
        check("after_busy_result", int'(res), 3'b100);
        check("after_busy_latency", lat, 5);

        // Asynchronous reset in cycle 3 of an equal-operand compare.
        @(negedge clk);
        a16 = 16'hABCD; b16 = 16'hABCD; sgn16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", int'({busy16, done16, gt16, eq16, lt16}), 0);
        ndone = 0;
        repeat (2) begin @(negedge clk); if (done16) ndone++; end
        rst_n = 1'b1;
        repeat (6) begin @(negedge clk); if (done16) ndone++; end
        check("midrun_reset_no_done", ndone, 0);
        run16(16'h0005, 16'h0003, 1'b0, lat, res);
        check("post_reset_result", int'(res), 3'b100);

        // Random 16-bit compares, biased toward shared leading digits.
        for (int i = 0; i < 200; i++) begin
            ra16 = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb16 = ra16;
                1:       rb16 = ra16 ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
                default: rb16 = 16'($urandom);
            endcase
            rs = 1'($urandom);
            run16(ra16, rb16, rs, lat, res);
            check($sformatf("rnd%0d_result a=%h b=%h s=%0d", i, ra16, rb16, rs),
                  int'(res), int'(rel_onehot(ref_rel(16, rs, int'(ra16), int'(rb16)))));
            check($sformatf("rnd%0d_latency", i), lat,
                  ref_lat(16, 4, int'(ra16), int'(rb16)));
        end

        // Exhaustive 4-bit sweeps, both modes, digit sizes 4 and 1.
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    run4(4'(x), 4'(y), 1'(s), la, ra, lb, rb);
                    check($sformatf("w4d4 a=%0d b=%0d s=%0d result", x, y, s),
                          int'(ra), int'(rel_onehot(ref_rel(4, 1'(s), x, y))));
                    check($sformatf("w4d4 a=%0d b=%0d s=%0d latency", x, y, s),
                          la, ref_lat(4, 4, x, y));
                    check($sformatf("w4d1 a=%0d b=%0d s=%0d result", x, y, s),
                          int'(rb), int'(rel_onehot(ref_rel(4, 1'(s), x, y))));
                    check($sformatf("w4d1 a=%0d b=%0d s=%0d latency", x, y, s),
                          lb, ref_lat(4, 1, x, y));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_mag_compare.md
SEQ_MAG_COMPARE -- requirements
Module: seq_mag_compare

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits compared per cycle; WIDTH % DIGIT == 0 and DIGIT <= WIDTH are required; NDIG = WIDTH/DIGIT.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port: start  input  1  request a compare; sampled only in IDLE.
REQ-007 SHALL have port: is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-008 SHALL have port: a  input  WIDTH  left operand; sampled with start.
REQ-009 SHALL have port: b  input  WIDTH  right operand; sampled with start.
REQ-010 SHALL have port: busy  output  1  high in RUN and DONE.
REQ-011 SHALL have port: done  output  1  one-cycle pulse; results are valid from this cycle onward.
REQ-012 SHALL have ports: gt, eq, lt  output  1 each  registered result for a>b, a==b, a<b.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE with start=1 SHALL capture a, b and is_signed, set digit index to NDIG-1 (MS digit) and go to RUN.
- Signed mode: invert the MSB of both captured operands so that the unsigned compare is correct.
REQ-015 IDLE with start=0 SHALL stay in IDLE.
REQ-016 RUN SHALL compare the DIGIT-bit slices of the captured operands at the current index, one digit per cycle, MS digit first.
REQ-017 RUN with unequal digits SHALL latch gt/lt from that digit, clear eq, and go to DONE (early termination).
REQ-018 RUN with equal digits and index 0 SHALL latch eq=1, gt=0, lt=0 and go to DONE.
REQ-019 RUN with equal digits and index>0 SHALL decrement the index and stay in RUN.
REQ-020 DONE SHALL assert done=1 for exactly one cycle and then go to IDLE unconditionally.
REQ-021 Latency SHALL be fixed by the start edge:
- start sampled at edge 0; m digits examined (1..NDIG); done high in cycle m+1.
- Best case done is in cycle 2; worst case done is in cycle NDIG+1.
REQ-022 gt, eq and lt SHALL update only on the edge that enters DONE.
- Exactly one is high after the first completed compare.
- Values hold until the next DONE entry; they are not cleared at start.
REQ-023 start while busy=1 (RUN or DONE) SHALL be ignored; it is not queued, and the captured operands are not disturbed.
REQ-024 Changes on a, b or is_signed after capture SHALL NOT affect the result in progress.
REQ-025 busy SHALL be registered and derived from state only; done SHALL be high only in DONE.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, gt=0, eq=0, lt=0, and clear the digit index and operand registers.
REQ-027 Reset asserted mid-RUN SHALL abort the compare with no done pulse; the first start after release SHALL behave as from power-up.

Verification
REQ-028 W16/D4, unsigned, a=0x1234, b=0x1235 -> lt=1, gt=0, eq=0; done in cycle 5 (all 4 digits examined).
REQ-029 W16/D4, a=0x8000, b=0x7FFF:
- is_signed=0 -> gt=1, done in cycle 2.
- is_signed=1 -> lt=1, done in cycle 2.
REQ-030 W16/D4, a=b=0xABCD, either mode -> eq=1; done in cycle 5; results hold through 10 idle cycles while a/b toggle.
REQ-031 W16/D4, start pulsed in cycles 2 and 3 of a running compare with different a/b -> no effect; single done with the original result; next start in IDLE is accepted.
REQ-032 W16/D4, rst_n low in cycle 3 of an equal-operand compare -> all outputs 0 at once, no done; a new compare a=5, b=3 -> gt=1.
REQ-033 W4/D4 and W4/D1, exhaustive 256 unsigned and 256 signed pairs against a reference model -> exactly one of gt/eq/lt matches; latency per REQ-021.
